// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, sequencer state encoding and op legality check
package alu_pkg;
    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_ADD = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [15:0] op);
        return op <= 16'(ALU_SUB);
    endfunction
endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin grant; on a tie the requester not served last wins
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    logic ptr_q, ptr_d, win;

    always_comb begin
        win   = req_i[ptr_q] ? ptr_q : ~ptr_q;
        gnt_o = (en_i && req_i[win]) ? (2'b01 << win) : 2'b00;
        ptr_d = (|gnt_o) ? ~win : ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= 1'b0;
        else         ptr_q <= ptr_d;
    end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between the execute stage (req 0) and the
// branch/address unit (req 1); holds operands for SETTLE_CYCLES, then returns a registered result.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int CTRL_W        = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    input  logic [CTRL_W-1:0] req0_op_i,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    input  logic [CTRL_W-1:0] req1_op_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_out_i,
    input  logic              alu_zero_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_id_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_zero_o,
    output logic              rsp_err_o,
    output logic              busy_o
);
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be within 1..15");
    end
    if (CTRL_W < 3) begin : g_bad_ctrl
        $error("CTRL_W must be at least 3");
    end

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
    logic [CTRL_W-1:0] op_q, op_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              id_q, id_d, zero_q, zero_d, err_q, err_d;
    logic [1:0]        gnt;
    logic              legal_q, drive;

    rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (state_q == ST_IDLE && rst_ni),
        .req_i  (req_valid_i),
        .gnt_o  (gnt)
    );

    // Illegal ops still spend one cycle in EXEC so both paths answer one edge after accept at minimum
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        zero_d  = zero_q;
        err_d   = err_q;
        legal_q = is_legal_op(16'(op_q));
        case (state_q)
            ST_IDLE: if (|gnt) begin
                a_d     = gnt[1] ? req1_a_i : req0_a_i;
                b_d     = gnt[1] ? req1_b_i : req0_b_i;
                op_d    = gnt[1] ? req1_op_i : req0_op_i;
                id_d    = gnt[1];
                cnt_d   = 4'(SETTLE_CYCLES - 1);
                state_d = ST_EXEC;
            end
            ST_EXEC: if (!legal_q) begin
                data_d  = '0;
                zero_d  = 1'b1;
                err_d   = 1'b1;
                state_d = ST_RESP;
            end else if (cnt_q == 4'd0) begin
                data_d  = alu_out_i;
                zero_d  = alu_zero_i;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            id_q    <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign drive       = state_q == ST_EXEC && legal_q;
    assign alu_a_o     = drive ? a_q : '0;
    assign alu_b_o     = drive ? b_q : '0;
    assign alu_ctrl_o  = drive ? op_q : CTRL_W'(ALU_NOP);
    assign req_ready_o = gnt;
    assign rsp_valid_o = state_q == ST_RESP;
    assign rsp_id_o    = id_q;
    assign rsp_data_o  = data_q;
    assign rsp_zero_o  = zero_q;
    assign rsp_err_o   = err_q;
    assign busy_o      = state_q != ST_IDLE;
endmodule
